// File: rtl/vga_pattern_source.sv
// Pixel-colour generator placed after the VGA timing controller.
// Produces registered 24-bit RGB from Column/Row/Display. Four test patterns
// are available (colour bars, checkerboard, gradient, moving box), with
// optional per-frame auto-cycling driven by the vsync assertion edge.
module vga_pattern_source #(
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned V_ACTIVE        = 480,
    parameter int unsigned START_PATTERN   = 0,
    parameter int unsigned AUTO_CYCLE      = 1,
    parameter int unsigned FRAMES_PER_PAT  = 60,
    parameter int unsigned BOX_SIZE        = 64,
    parameter int unsigned SYNC_ACTIVE_LOW = 1
) (
    input  logic       pxclk,
    input  logic       rst,
    input  logic       Display,
    input  logic [9:0] Column,
    input  logic [9:0] Row,
    input  logic       hsync_out,
    input  logic       vsync_out,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue
);

    localparam int unsigned BAR_W     = H_ACTIVE / 8;
    localparam int unsigned BOX_X_MAX = H_ACTIVE - BOX_SIZE;
    localparam int unsigned BOX_Y_LO  = (V_ACTIVE - BOX_SIZE) / 2;
    localparam int unsigned BOX_Y_HI  = (V_ACTIVE + BOX_SIZE) / 2;
    localparam int unsigned FC_W      = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;
    localparam logic        VS_IDLE   = (SYNC_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] C_CYAN    = 24'h00FFFF;
    localparam logic [23:0] C_GREEN   = 24'h00FF00;
    localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] C_RED     = 24'hFF0000;
    localparam logic [23:0] C_BLUE    = 24'h0000FF;
    localparam logic [23:0] C_BLACK   = 24'h000000;

    logic            r_vsync_d;
    logic [FC_W-1:0] r_frame_cnt;
    logic [1:0]      r_pattern;
    logic [10:0]     r_box_x;
    logic [23:0]     r_rgb;

    logic [10:0]     w_col;
    logic [10:0]     w_row;
    logic            w_frame_tick;
    logic            w_visible;
    logic            w_in_box;
    logic [2:0]      w_bar_idx;
    logic [23:0]     w_rgb;

    // hsync is only monitored; it never affects colour
    logic            w_unused_hsync;
    assign w_unused_hsync = hsync_out;

    assign w_col        = {1'b0, Column};
    assign w_row        = {1'b0, Row};
    assign w_frame_tick = (vsync_out != VS_IDLE) && (r_vsync_d == VS_IDLE);
    assign w_visible    = Display && (w_col < 11'(H_ACTIVE)) && (w_row < 11'(V_ACTIVE));
    assign w_in_box     = (w_col >= r_box_x) && (w_col < (r_box_x + 11'(BOX_SIZE))) &&
                          (w_row >= 11'(BOX_Y_LO)) && (w_row < 11'(BOX_Y_HI));

    // Frame state: vsync edge detect, box position, frame counter and pattern select
    always_ff @(posedge pxclk or posedge rst) begin
        if (rst) begin
            r_vsync_d   <= VS_IDLE;
            r_frame_cnt <= '0;
            r_pattern   <= 2'(START_PATTERN);
            r_box_x     <= '0;
        end else begin
            r_vsync_d <= vsync_out;
            if (w_frame_tick) begin
                if (r_box_x >= 11'(BOX_X_MAX)) begin
                    r_box_x <= '0;
                end else begin
                    r_box_x <= r_box_x + 11'd1;
                end
                if (AUTO_CYCLE != 0) begin
                    if (r_frame_cnt == FC_W'(FRAMES_PER_PAT - 1)) begin
                        r_frame_cnt <= '0;
                        r_pattern   <= r_pattern + 2'd1;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + FC_W'(1);
                    end
                end
            end
        end
    end

    // Colour-bar index from a bank of column comparators (no divider)
    always_comb begin
        w_bar_idx = '0;
        for (int k = 1; k < 8; k++) begin
            if (w_col >= 11'(k * BAR_W)) begin
                w_bar_idx = w_bar_idx + 3'd1;
            end
        end
    end

    // Next pixel colour for the selected pattern, black outside the visible area
    always_comb begin
        w_rgb = C_BLACK;
        if (w_visible) begin
            case (r_pattern)
                2'd0: begin
                    case (w_bar_idx)
                        3'd0:    w_rgb = C_WHITE;
                        3'd1:    w_rgb = C_YELLOW;
                        3'd2:    w_rgb = C_CYAN;
                        3'd3:    w_rgb = C_GREEN;
                        3'd4:    w_rgb = C_MAGENTA;
                        3'd5:    w_rgb = C_RED;
                        3'd6:    w_rgb = C_BLUE;
                        default: w_rgb = C_BLACK;
                    endcase
                end
                2'd1:    w_rgb = (Column[5] ^ Row[5]) ? C_WHITE : C_BLACK;
                2'd2:    w_rgb = {Column[9:2], Row[8:1], ~Column[9:2]};
                default: w_rgb = w_in_box ? C_WHITE : C_BLUE;
            endcase
        end
    end

    // Output register: one pxclk after the Column/Row/Display sample
    always_ff @(posedge pxclk or posedge rst) begin
        if (rst) begin
            r_rgb <= '0;
        end else begin
            r_rgb <= w_rgb;
        end
    end

    assign red   = r_rgb[23:16];
    assign green = r_rgb[15:8];
    assign blue  = r_rgb[7:0];

endmodule

// File: tb/tb_vga_pattern_source.sv
// Scoreboard bench for vga_pattern_source: a driver issues pixels/sync each
// cycle and pushes the reference colour; a monitor pops and compares one
// entry per cycle after the output register updates.
module tb_vga_pattern_source;

    localparam int H   = 640;
    localparam int V   = 480;
    localparam int SP  = 0;
    localparam int AC  = 1;
    localparam int FPP = 2;
    localparam int BOX = 64;

    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic       pxclk = 1'b0;
    logic       rst;
    logic       Display;
    logic [9:0] Column;
    logic [9:0] Row;
    logic       hsync_out;
    logic       vsync_out;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;

    typedef struct {
        logic [23:0] rgb;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errs   = 0;
    int   m_ticks  = 0;
    logic m_prev_vs = 1'b1;
    logic rst_req   = 1'b1;

    vga_pattern_source #(
        .H_ACTIVE(H), .V_ACTIVE(V), .START_PATTERN(SP), .AUTO_CYCLE(AC),
        .FRAMES_PER_PAT(FPP), .BOX_SIZE(BOX), .SYNC_ACTIVE_LOW(1)
    ) dut (
        .pxclk(pxclk), .rst(rst), .Display(Display), .Column(Column), .Row(Row),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .red(red), .green(green), .blue(blue)
    );

    always #5 pxclk = ~pxclk;

    // Reference: pattern and box position follow directly from the tick count
    function automatic int model_pattern();
        return (SP + ((AC != 0) ? (m_ticks / FPP) : 0)) % 4;
    endfunction

    function automatic int model_box_x();
        return m_ticks % (H - BOX + 1);
    endfunction

    function automatic logic [23:0] model_rgb(input logic disp, input int col, input int row);
        int bx;
        if (!disp || col >= H || row >= V) return 24'h000000;
        bx = model_box_x();
        case (model_pattern())
            0: return BARS[col / (H / 8)];
            1: return ((((col / 32) ^ (row / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
            2: return {8'((col / 4) % 256), 8'((row / 2) % 256), 8'(255 - ((col / 4) % 256))};
            default: begin
                if (col >= bx && col < bx + BOX && row >= (V - BOX) / 2 && row < (V + BOX) / 2)
                    return 24'hFFFFFF;
                return 24'h0000FF;
            end
        endcase
    endfunction

    // One pixel per cycle; the expected output for this sample is queued
    task automatic drive(input logic vs, input logic hs, input logic disp,
                         input int col, input int row, input string tag);
        exp_t e;
        @(negedge pxclk);
        rst       = rst_req;
        vsync_out = vs;
        hsync_out = hs;
        Display   = disp;
        Column    = 10'(col);
        Row       = 10'(row);
        e.rgb = rst_req ? 24'h000000 : model_rgb(disp, col, row);
        e.tag = tag;
        sb_q.push_back(e);
        if (rst_req) begin
            m_ticks   = 0;
            m_prev_vs = 1'b1;
        end else begin
            if (vs == 1'b0 && m_prev_vs == 1'b1) m_ticks++;
            m_prev_vs = vs;
        end
    endtask

    function automatic int rcol();
        return int'($urandom_range(0, 700));
    endfunction

    function automatic int rrow();
        return int'($urandom_range(0, 520));
    endfunction

    // One vsync low pulse with random pixel traffic
    task automatic pulse();
        for (int i = 0; i < 4; i++) begin
            drive((i < 2) ? 1'b0 : 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  rcol(), rrow(), "pulse_traffic");
        end
    endtask

    task automatic box_edges(input string tag);
        int bx;
        bx = model_box_x();
        drive(1, 0, 1, bx - 1, 240, {tag, "_left_out"});
        drive(1, 0, 1, bx, 240, {tag, "_left_in"});
        drive(1, 0, 1, bx + BOX - 1, 240, {tag, "_right_in"});
        drive(1, 0, 1, bx + BOX, 240, {tag, "_right_out"});
        drive(1, 0, 1, bx, 207, {tag, "_top_out"});
        drive(1, 0, 1, bx, 208, {tag, "_top_in"});
        drive(1, 0, 1, bx, 271, {tag, "_bot_in"});
        drive(1, 0, 1, bx, 272, {tag, "_bot_out"});
    endtask

    // Monitor: compare after each output register update
    initial begin
        exp_t e;
        forever begin
            @(posedge pxclk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if ({red, green, blue} !== e.rgb) begin
                    n_errs++;
                    $display("FAIL %s: rgb=%06h expected %06h at %0t", e.tag, {red, green, blue}, e.rgb, $time);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rst_req = 1'b1;
        Display = 1'b0; Column = '0; Row = '0; hsync_out = 1'b1; vsync_out = 1'b1;

        // Reset hold and release with blanking
        repeat (3) drive(1, 0, 0, rcol(), rrow(), "reset_hold");
        rst_req = 1'b0;
        repeat (3) drive(1, 0, 0, rcol(), rrow(), "post_reset_blank");

        // Colour bars incl. bar edges and horizontal blanking
        drive(1, 0, 1, 0, 10, "bar_col0");
        drive(1, 0, 1, 85, 10, "bar_col85");
        drive(1, 0, 1, 479, 10, "bar_col479");
        drive(1, 0, 1, 639, 10, "bar_col639");
        drive(1, 0, 1, 79, 10, "bar_col79");
        drive(1, 0, 1, 80, 10, "bar_col80");
        drive(1, 0, 1, 640, 10, "blank_col640");
        drive(1, 0, 1, 10, 480, "blank_row480");

        // Two frames advance to the checkerboard
        repeat (2) pulse();
        drive(1, 0, 1, 0, 0, "chk_0_0");
        drive(1, 0, 1, 32, 0, "chk_32_0");
        drive(1, 0, 1, 32, 32, "chk_32_32");
        drive(1, 0, 0, 32, 0, "chk_display_off");

        // hsync activity alone must not change the pattern
        for (int i = 0; i < 16; i++) drive(1, 1'(i % 2), 1, 100, 10, "hsync_only");
        repeat (6) pulse();
        drive(1, 0, 1, 100, 10, "cycle_back_to_0");

        // Moving box
        for (int i = 0; i < 16 && model_pattern() != 3; i++) pulse();
        box_edges("box_early");
        while (m_ticks < 575) pulse();
        box_edges("box_far_right");
        for (int i = 0; i < 16 && m_ticks < 582; i++) pulse();
        box_edges("box_wrapped");
        drive(1, 0, 1, 575, 240, "box_wrapped_old_pos");

        // Random traffic with random frame ticks
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), rcol(), rrow(), "random");
        end

        // Gradient, then asynchronous reset mid-line
        for (int i = 0; i < 16 && model_pattern() != 2; i++) pulse();
        drive(1, 0, 1, 400, 300, "grad_400_300");
        @(posedge pxclk);
        #3;
        rst_req = 1'b1;
        rst     = 1'b1;
        #1;
        n_checks++;
        if ({red, green, blue} !== 24'h000000) begin
            n_errs++;
            $display("FAIL async_reset: rgb=%06h expected 000000", {red, green, blue});
        end
        repeat (2) drive(1, 0, 1, 400, 300, "reset_mid_line");
        rst_req = 1'b0;
        drive(1, 0, 1, 100, 10, "after_reset_pattern0");
        drive(1, 0, 1, 400, 300, "after_reset_bar");

        repeat (2) @(posedge pxclk);
        #3;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errs++;
            $display("FAIL scoreboard_drain: pending=%0d expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
